// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver: the frame state
// machine encoding and the two prefix byte values that the receiver folds
// into the extended/released qualifiers instead of reporting as codes.
package ps2_pkg;

    // Frame position: waiting for a start bit, shifting data bits,
    // expecting the parity bit, expecting the stop bit.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Prefix bytes sent by the keyboard ahead of the real scan code.
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_REL = 8'hF0;

endpackage

// File: rtl/ps2_filter.sv
// ps2_filter
// Brings one raw, asynchronous PS/2 pin into the clock domain and removes
// short glitches. The filtered level only follows the synchronised pin once
// it has shown the same new value for FILTER_LEN consecutive samples.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset; filtered level resets to 1
//   pin_i    raw pin, asynchronous to clk
//   level_o  synchronised and de-glitched level
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic level_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // Two-flop synchroniser followed by the run-length filter. The counter
    // tracks how many samples in a row have disagreed with the current
    // filtered level; any agreeing sample restarts the run, so a glitch
    // shorter than FILTER_LEN never reaches the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx
// PS/2 keyboard receiver. Deserialises 11-bit device-to-host frames
// (start, 8 data LSB first, odd parity, stop), abandons frames that stall,
// and folds E0/F0 prefix bytes into qualifiers on the following scan code.
//
// Ports:
//   clk         system clock (cpu_clk)
//   reset_n     asynchronous active-low reset
//   ps2_clk     raw PS/2 clock pin
//   ps2_data    raw PS/2 data pin
//   code        last completed scan code (prefixes excluded)
//   extended    an E0 prefix preceded code
//   released    an F0 prefix preceded code
//   code_valid  one-cycle strobe: code/extended/released are new
//   parity_err  one-cycle strobe: parity failure
//   frame_err   one-cycle strobe: bad start, bad stop or timeout
//   busy        receiver is mid-frame
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 6000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       extended,
    output logic       released,
    output logic       code_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic          clk_f;
    logic          data_f;

    ps2_state_t    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic          clk_prev_q;
    logic          ext_pend_q;
    logic          rel_pend_q;
    logic [7:0]    code_q;
    logic          extended_q;
    logic          released_q;
    logic          code_valid_q;
    logic          parity_err_q;
    logic          frame_err_q;

    logic          fall;
    logic          tmo_hit;
    logic          parity_ok;
    logic [7:0]    shift_d;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (ps2_clk),
        .level_o (clk_f)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (ps2_data),
        .level_o (data_f)
    );

    // Falling edge of the filtered clock is the bit-sample moment. The
    // timeout fires one count short of TIMEOUT on the registered value so
    // that the abandon decision lands TIMEOUT cycles after the last edge.
    // Odd parity means the nine bits together must XOR to 1.
    always_comb begin
        fall      = clk_prev_q & ~clk_f;
        tmo_hit   = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT - 1));
        parity_ok = ^{shift_q, parity_q};
        shift_d   = {data_f, shift_q[7:1]};
    end

    // Frame FSM, stall timer and prefix layer in one register block so that
    // every output strobe is registered. An edge always takes priority over
    // a timeout in the same cycle. Any error drops pending prefixes so a
    // corrupted sequence cannot tag an unrelated later code.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            clk_prev_q   <= 1'b1;
            ext_pend_q   <= 1'b0;
            rel_pend_q   <= 1'b0;
            code_q       <= '0;
            extended_q   <= 1'b0;
            released_q   <= 1'b0;
            code_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_prev_q   <= clk_f;
            code_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (fall || state_q == IDLE) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!data_f) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                            ext_pend_q  <= 1'b0;
                            rel_pend_q  <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        parity_q <= data_f;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!data_f) begin
                            frame_err_q <= 1'b1;
                            ext_pend_q  <= 1'b0;
                            rel_pend_q  <= 1'b0;
                        end else if (!parity_ok) begin
                            parity_err_q <= 1'b1;
                            ext_pend_q   <= 1'b0;
                            rel_pend_q   <= 1'b0;
                        end else if (shift_q == PS2_EXT) begin
                            ext_pend_q <= 1'b1;
                        end else if (shift_q == PS2_REL) begin
                            rel_pend_q <= 1'b1;
                        end else begin
                            code_q       <= shift_q;
                            extended_q   <= ext_pend_q;
                            released_q   <= rel_pend_q;
                            code_valid_q <= 1'b1;
                            ext_pend_q   <= 1'b0;
                            rel_pend_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end else if (tmo_hit) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
                ext_pend_q  <= 1'b0;
                rel_pend_q  <= 1'b0;
            end
        end
    end

    assign code       = code_q;
    assign extended   = extended_q;
    assign released   = released_q;
    assign code_valid = code_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx
// Drives PS/2 frames at 400 clocks per bit into ps2_rx and checks every
// strobe against a byte-level model of the keyboard protocol, plus literal
// expectations on the held code/qualifier outputs.
module tb_ps2_rx;

    logic       clk;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       extended;
    logic       released;
    logic       code_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    // Expected strobe events: kind 0 = code_valid, 1 = parity_err, 2 = frame_err
    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } exp_t;

    exp_t expQ[$];
    logic modelExt;
    logic modelRel;
    int   testsRun;
    int   testsFailed;
    int   cycle;
    int   lastFall;
    logic busySeen;
    logic prevStrobe;

    ps2_rx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .extended   (extended),
        .released   (released),
        .code_valid (code_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // Free-running clock and a cycle counter used to time the stall abandon.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, actual, expected);
        end
    endtask

    // Protocol model: what a keyboard byte must turn into at the output.
    task automatic modelFrame(input logic [7:0] b, input logic badPar, input logic badStop);
        exp_t e;
        e.code = 8'h00;
        e.ext  = 1'b0;
        e.rel  = 1'b0;
        if (badStop) begin
            e.kind = 2;
            expQ.push_back(e);
            modelExt = 1'b0;
            modelRel = 1'b0;
        end else if (badPar) begin
            e.kind = 1;
            expQ.push_back(e);
            modelExt = 1'b0;
            modelRel = 1'b0;
        end else if (b == 8'hE0) begin
            modelExt = 1'b1;
        end else if (b == 8'hF0) begin
            modelRel = 1'b1;
        end else begin
            e.kind = 0;
            e.code = b;
            e.ext  = modelExt;
            e.rel  = modelRel;
            expQ.push_back(e);
            modelExt = 1'b0;
            modelRel = 1'b0;
        end
    endtask

    // Shift out the first n bits of a frame, LSB first; data changes in the
    // middle of the high phase and is sampled on the falling clock.
    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (100) @(negedge clk);
            ps2_data = bits[i];
            repeat (100) @(negedge clk);
            ps2_clk  = 1'b0;
            lastFall = cycle;
            repeat (200) @(negedge clk);
            ps2_clk  = 1'b1;
        end
        repeat (100) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic badPar, input logic badStop);
        logic [10:0] bits;
        modelFrame(b, badPar, badStop);
        bits = {~badStop, (~^b) ^ badPar, b, 1'b0};
        sendBits(bits, 11);
        repeat (300) @(negedge clk);
    endtask

    // Compare process: every strobe must match the next modelled event, be
    // the only strobe that cycle, and last exactly one cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            int   n;
            exp_t e;
            if (busy) busySeen = 1'b1;
            n = int'(code_valid) + int'(parity_err) + int'(frame_err);
            if (n > 0) begin
                checkOutput("strobe_exclusive", n, 1);
                checkOutput("strobe_width", int'(prevStrobe), 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_strobe", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("strobe_kind", frame_err ? 2 : (parity_err ? 1 : 0), e.kind);
                    if (e.kind == 0 && code_valid) begin
                        checkOutput("code", int'(code), int'(e.code));
                        checkOutput("extended", int'(extended), int'(e.ext));
                        checkOutput("released", int'(released), int'(e.rel));
                    end
                end
            end
            prevStrobe = (n > 0);
        end else begin
            prevStrobe = 1'b0;
        end
    end

    task automatic checkHeld(input string name, input logic [7:0] c, input logic x, input logic r);
        checkOutput({name, "_code"}, int'(code), int'(c));
        checkOutput({name, "_ext"}, int'(extended), int'(x));
        checkOutput({name, "_rel"}, int'(released), int'(r));
        checkOutput({name, "_qempty"}, expQ.size(), 0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_outs"},
                    int'({code, extended, released, code_valid, parity_err, frame_err, busy}), 0);
    endtask

    initial begin
        logic [10:0] partial;
        testsRun    = 0;
        testsFailed = 0;
        cycle       = 0;
        lastFall    = 0;
        modelExt    = 1'b0;
        modelRel    = 1'b0;
        busySeen    = 1'b0;
        prevStrobe  = 1'b0;
        reset_n     = 1'b0;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        repeat (5) @(negedge clk);
        checkAllZero("reset");
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // Plain make code; busy must be seen during the frame and clear after
        busySeen = 1'b0;
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("t1_busy_seen", int'(busySeen), 1);
        checkOutput("t1_busy_after", int'(busy), 0);
        checkHeld("t1", 8'h1C, 1'b0, 1'b0);

        // Break code
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkHeld("t2", 8'h1C, 1'b0, 1'b1);

        // Extended break
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0);
        checkHeld("t3", 8'h75, 1'b1, 1'b1);

        // Parity error discards the pending release prefix
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b1, 1'b0);
        checkHeld("t4a", 8'h75, 1'b1, 1'b1);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkHeld("t4b", 8'h1C, 1'b0, 1'b0);

        // Bad stop bit
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'h2A, 1'b0, 1'b1);
        applyStimulus(8'h6B, 1'b0, 1'b0);
        checkHeld("tstop", 8'h6B, 1'b0, 1'b0);

        // Short clock glitch in idle must be ignored
        busySeen = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("t5_glitch_busy", int'(busySeen), 0);

        // Stalled frame: start + 4 data bits, then silence
        modelFrame(8'h00, 1'b0, 1'b1);
        partial = {1'b1, 1'b0, 8'h1C, 1'b0};
        sendBits(partial, 5);
        checkOutput("t5_busy_mid", int'(busy), 1);
        while (!frame_err && (cycle - lastFall) < 8000) @(negedge clk);
        checkOutput("t5_timeout_latency", cycle - lastFall, 2 + 8 + 6001);
        checkOutput("t5_busy_after", int'(busy), 0);
        repeat (50) @(negedge clk);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkHeld("t5", 8'h1C, 1'b0, 1'b0);

        // Asynchronous reset mid-frame drops the pending E0
        applyStimulus(8'hE0, 1'b0, 1'b0);
        sendBits(partial, 5);
        repeat (50) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkAllZero("t6_reset");
        modelExt = 1'b0;
        modelRel = 1'b0;
        expQ.delete();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkHeld("t6", 8'h1C, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
